// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status register block for the accelerator: config fields, engine start strobes, done status.
// W_IDLE | wait for AWVALID && WVALID ; W_ACK | AW/W ready, update regs ; W_RESP | BVALID until BREADY
// R_IDLE | wait for ARVALID ; R_ACK | ARREADY, capture RDATA ; R_DATA | RVALID until RREADY
module axi_lite_ctrl_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [11:0]                     ofmaps_channel,
   output logic [11:0]                     input_channel,
   output logic [1:0]                      func,
   output logic [8:0]                      ofmaps_width,
   output logic [2:0]                      stride,
   output logic [4:0]                      kernel_size,
   output logic                            compute_start,
   output logic                            load_ifmaps_start,
   output logic                            write_weight_start,
   input  logic                            weight_done,
   input  logic                            compute_done
);

   localparam logic [1:0] W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2;
   localparam logic [1:0] R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2;

   logic [1:0]  r_wstate, r_rstate;
   logic [31:0] r_reg0;
   logic [13:0] r_reg1;
   logic [4:0]  r_reg2;
   logic        r_weight_finish, r_compute_finish;
   logic        r_compute_start, r_load_ifmaps_start, r_write_weight_start;
   logic [31:0] r_rdata;
   logic        w_wr_en, w_instr_wr;
   logic [1:0]  w_widx;
   logic [31:0] w_rd_mux;
   logic        w_unused;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wstate <= W_IDLE;
      end else begin
         case (r_wstate)
            W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) r_wstate <= W_ACK;
            W_ACK:   r_wstate <= W_RESP;
            W_RESP:  if (S_AXI_BREADY) r_wstate <= W_IDLE;
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   assign w_wr_en    = (r_wstate == W_ACK);
   assign w_widx     = S_AXI_AWADDR[3:2];
   assign w_instr_wr = w_wr_en && (w_widx == 2'd0) && S_AXI_WSTRB[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reg0 <= '0;
         r_reg1 <= '0;
         r_reg2 <= '0;
      end else if (w_wr_en) begin
         case (w_widx)
            2'd0: begin
               for (int b = 0; b < 4; b++)
                  if (S_AXI_WSTRB[b]) r_reg0[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
            2'd1: begin
               if (S_AXI_WSTRB[0]) r_reg1[7:0]  <= S_AXI_WDATA[7:0];
               if (S_AXI_WSTRB[1]) r_reg1[13:8] <= S_AXI_WDATA[13:8];
            end
            2'd2: if (S_AXI_WSTRB[0]) r_reg2 <= S_AXI_WDATA[4:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_compute_start      <= 1'b0;
         r_load_ifmaps_start  <= 1'b0;
         r_write_weight_start <= 1'b0;
      end else begin
         r_compute_start      <= w_instr_wr && (S_AXI_WDATA[7:0] == 8'd87);
         r_load_ifmaps_start  <= w_instr_wr && (S_AXI_WDATA[7:0] == 8'd88);
         r_write_weight_start <= w_instr_wr && (S_AXI_WDATA[7:0] == 8'd12);
      end
   end

   // A done pulse coinciding with the clearing strobe must leave the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_weight_finish  <= 1'b0;
         r_compute_finish <= 1'b0;
      end else begin
         if (weight_done)               r_weight_finish  <= 1'b1;
         else if (r_write_weight_start) r_weight_finish  <= 1'b0;
         if (compute_done)              r_compute_finish <= 1'b1;
         else if (r_compute_start)      r_compute_finish <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate <= R_IDLE;
      end else begin
         case (r_rstate)
            R_IDLE:  if (S_AXI_ARVALID) r_rstate <= R_ACK;
            R_ACK:   r_rstate <= R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_rstate <= R_IDLE;
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (S_AXI_ARADDR[3:2])
         2'd0:    w_rd_mux = r_reg0;
         2'd1:    w_rd_mux = {18'd0, r_reg1};
         2'd2:    w_rd_mux = {27'd0, r_reg2};
         default: w_rd_mux = {30'd0, r_compute_finish, r_weight_finish};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_rdata <= '0;
      else if (r_rstate == R_ACK) r_rdata <= w_rd_mux;
   end

   assign S_AXI_AWREADY      = w_wr_en;
   assign S_AXI_WREADY       = w_wr_en;
   assign S_AXI_BVALID       = (r_wstate == W_RESP);
   assign S_AXI_BRESP        = 2'b00;
   assign S_AXI_ARREADY      = (r_rstate == R_ACK);
   assign S_AXI_RVALID       = (r_rstate == R_DATA);
   assign S_AXI_RRESP        = 2'b00;
   assign S_AXI_RDATA        = r_rdata;
   assign ofmaps_channel     = r_reg0[31:20];
   assign input_channel      = r_reg0[19:8];
   assign func               = r_reg1[1:0];
   assign ofmaps_width       = r_reg1[10:2];
   assign stride             = r_reg1[13:11];
   assign kernel_size        = r_reg2;
   assign compute_start      = r_compute_start;
   assign load_ifmaps_start  = r_load_ifmaps_start;
   assign write_weight_start = r_write_weight_start;

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Bench for axi_lite_ctrl_regs: fixed vectors, hand-written corner sequences, and random traffic vs a register model.
module tb_axi_lite_ctrl_regs;

   logic        clk = 1'b0, rst = 1'b1;
   logic [3:0]  awaddr = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [11:0] ofmaps_channel, input_channel;
   logic [1:0]  func;
   logic [8:0]  ofmaps_width;
   logic [2:0]  stride;
   logic [4:0]  kernel_size;
   logic        compute_start, load_ifmaps_start, write_weight_start;
   logic        weight_done = 1'b0, compute_done = 1'b0;

   int checks = 0, failures = 0;
   int cnt_c = 0, cnt_l = 0, cnt_w = 0;

   // register model
   logic [31:0] m_reg [4];
   bit m_wf, m_cf;
   int e_c, e_l, e_w;

   axi_lite_ctrl_regs dut (
      .clk(clk), .rst(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .ofmaps_channel(ofmaps_channel), .input_channel(input_channel), .func(func),
      .ofmaps_width(ofmaps_width), .stride(stride), .kernel_size(kernel_size),
      .compute_start(compute_start), .load_ifmaps_start(load_ifmaps_start),
      .write_weight_start(write_weight_start), .weight_done(weight_done), .compute_done(compute_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (compute_start)      cnt_c++;
      if (load_ifmaps_start)  cnt_l++;
      if (write_weight_start) cnt_w++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_wf = 0; m_cf = 0;
   endtask

   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'(a[3:2]);
      if (idx != 3)
         for (int b = 0; b < 4; b++) if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
      m_reg[1] = m_reg[1] & 32'h0000_3FFF;
      m_reg[2] = m_reg[2] & 32'h0000_001F;
      if (idx == 0 && s[0]) begin
         if (d[7:0] == 8'd87) begin e_c++; m_cf = 0; end
         if (d[7:0] == 8'd88) e_l++;
         if (d[7:0] == 8'd12) begin e_w++; m_wf = 0; end
      end
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a);
      if (a[3:2] == 2'd3) return {30'd0, m_cf, m_wf};
      return m_reg[a[3:2]];
   endfunction

   task automatic check_fields();
      chk("ofmaps_channel", 32'(ofmaps_channel), 32'(m_reg[0][31:20]));
      chk("input_channel",  32'(input_channel),  32'(m_reg[0][19:8]));
      chk("func",           32'(func),           32'(m_reg[1][1:0]));
      chk("ofmaps_width",   32'(ofmaps_width),   32'(m_reg[1][10:2]));
      chk("stride",         32'(stride),         32'(m_reg[1][13:11]));
      chk("kernel_size",    32'(kernel_size),    32'(m_reg[2][4:0]));
      chk("compute_start_count", 32'(cnt_c), 32'(e_c));
      chk("load_start_count",    32'(cnt_l), 32'(e_l));
      chk("weight_start_count",  32'(cnt_w), 32'(e_w));
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int hold, input bit done_w);
      int n = 0;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      while (!(awready && wready) && n < 16) begin @(negedge clk); n++; end
      chk("awready_latency", 32'(n), 32'd0);
      @(negedge clk);
      chk("bvalid_after_hs", 32'(bvalid), 32'd1);
      chk("bresp", 32'(bresp), 32'd0);
      if (done_w) weight_done = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         weight_done = 1'b0;
         chk("no_second_hs", 32'({awready, wready}), 32'd0);
         chk("bvalid_held", 32'(bvalid), 32'd1);
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      @(negedge clk);
      weight_done = 1'b0; bready = 1'b0;
      chk("bvalid_cleared", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [3:0] a, input int stall, input logic [31:0] exp);
      int n = 0;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      @(negedge clk);
      while (!arready && n < 16) begin @(negedge clk); n++; end
      chk("arready_latency", 32'(n), 32'd0);
      @(negedge clk);
      arvalid = 1'b0;
      chk("rvalid", 32'(rvalid), 32'd1);
      chk("rdata", rdata, exp);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("rvalid_stall", 32'(rvalid), 32'd1);
         chk("rdata_stall", rdata, exp);
         chk("arready_stall", 32'(arready), 32'd0);
      end
      chk("rresp", 32'(rresp), 32'd0);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("rvalid_cleared", 32'(rvalid), 32'd0);
   endtask

   task automatic pulse_done(input bit w);
      @(negedge clk);
      if (w) weight_done = 1'b1; else compute_done = 1'b1;
      @(negedge clk);
      weight_done = 1'b0; compute_done = 1'b0;
      if (w) m_wf = 1; else m_cf = 1;
   endtask

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [11:0] ofm, inch;
      logic [1:0]  fn;
      logic [8:0]  wid;
      logic [2:0]  str;
      logic [4:0]  ks;
      int          dc, dl, dw;
      logic [31:0] rd;
   } vec_t;

   vec_t vt [8];

   initial begin
      int bc, bl, bw;
      logic [3:0]  ra;
      logic [31:0] rd_d;
      logic [7:0]  codes [3];

      codes[0] = 8'd87; codes[1] = 8'd88; codes[2] = 8'd12;
      vt[0] = '{4'h8, 32'h0000_0002, 4'hF, 12'd0, 12'd0, 2'd0, 9'd0, 3'd0, 5'b00010, 0, 0, 0, 32'h0000_0002};
      vt[1] = '{4'h0, 32'h0020_0200, 4'hE, 12'd2, 12'd2, 2'd0, 9'd0, 3'd0, 5'b00010, 0, 0, 0, 32'h0020_0200};
      vt[2] = '{4'h0, 32'h0000_0057, 4'h1, 12'd2, 12'd2, 2'd0, 9'd0, 3'd0, 5'b00010, 1, 0, 0, 32'h0020_0257};
      vt[3] = '{4'h4, 32'h0000_100D, 4'hF, 12'd2, 12'd2, 2'd1, 9'd3, 3'd2, 5'b00010, 0, 0, 0, 32'h0000_100D};
      vt[4] = '{4'h0, 32'hFFFF_FF58, 4'h1, 12'd2, 12'd2, 2'd1, 9'd3, 3'd2, 5'b00010, 0, 1, 0, 32'h0020_0258};
      vt[5] = '{4'h0, 32'h0000_000C, 4'hE, 12'd0, 12'd0, 2'd1, 9'd3, 3'd2, 5'b00010, 0, 0, 0, 32'h0000_0058};
      vt[6] = '{4'hC, 32'hFFFF_FFFF, 4'hF, 12'd0, 12'd0, 2'd1, 9'd3, 3'd2, 5'b00010, 0, 0, 0, 32'h0000_0000};
      vt[7] = '{4'h8, 32'h0000_001F, 4'hE, 12'd0, 12'd0, 2'd1, 9'd3, 3'd2, 5'b00010, 0, 0, 0, 32'h0000_0002};

      model_reset();
      e_c = 0; e_l = 0; e_w = 0;
      repeat (3) @(negedge clk);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready",  32'(wready),  32'd0);
      chk("rst_bvalid",  32'(bvalid),  32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_rvalid",  32'(rvalid),  32'd0);
      chk("rst_rdata",   rdata,        32'd0);
      chk("rst_strobes", 32'({compute_start, load_ifmaps_start, write_weight_start}), 32'd0);
      check_fields();
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         bc = cnt_c; bl = cnt_l; bw = cnt_w;
         axi_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 1'b0);
         model_write(vt[i].addr, vt[i].data, vt[i].strb);
         chk("vec_ofmaps_channel", 32'(ofmaps_channel), 32'(vt[i].ofm));
         chk("vec_input_channel",  32'(input_channel),  32'(vt[i].inch));
         chk("vec_func",           32'(func),           32'(vt[i].fn));
         chk("vec_ofmaps_width",   32'(ofmaps_width),   32'(vt[i].wid));
         chk("vec_stride",         32'(stride),         32'(vt[i].str));
         chk("vec_kernel_size",    32'(kernel_size),    32'(vt[i].ks));
         chk("vec_compute_strobes", 32'(cnt_c - bc), 32'(vt[i].dc));
         chk("vec_load_strobes",    32'(cnt_l - bl), 32'(vt[i].dl));
         chk("vec_weight_strobes",  32'(cnt_w - bw), 32'(vt[i].dw));
         axi_read(vt[i].addr, 0, vt[i].rd);
      end

      // weight status set/clear
      bw = cnt_w;
      axi_write(4'h0, 32'h0000_000C, 4'h1, 0, 1'b0);
      model_write(4'h0, 32'h0000_000C, 4'h1);
      chk("weight_start_once", 32'(cnt_w - bw), 32'd1);
      axi_read(4'hC, 0, 32'd0);
      pulse_done(1'b1);
      axi_read(4'hC, 0, 32'd1);
      axi_write(4'h0, 32'h0000_000C, 4'h1, 0, 1'b0);
      model_write(4'h0, 32'h0000_000C, 4'h1);
      axi_read(4'hC, 0, 32'd0);
      pulse_done(1'b0);
      axi_read(4'hC, 0, 32'd2);

      // master keeps valids high during the response
      bc = cnt_c;
      axi_write(4'h0, 32'h0000_0057, 4'h1, 5, 1'b0);
      model_write(4'h0, 32'h0000_0057, 4'h1);
      chk("held_valid_single_strobe", 32'(cnt_c - bc), 32'd1);
      axi_read(4'hC, 0, 32'd0);

      // read stall with RREADY low
      pulse_done(1'b1);
      axi_read(4'hC, 4, 32'd1);

      // done coinciding with its clearing strobe
      axi_write(4'h0, 32'h0000_000C, 4'h1, 0, 1'b1);
      model_write(4'h0, 32'h0000_000C, 4'h1);
      m_wf = 1;
      axi_read(4'hC, 0, 32'd1);
      check_fields();

      // simultaneous read and write of REG0: read returns pre-write value
      rd_d = model_read(4'h0);
      fork
         axi_write(4'h0, 32'hABCD_E011, 4'hF, 0, 1'b0);
         axi_read(4'h0, 0, rd_d);
      join
      model_write(4'h0, 32'hABCD_E011, 4'hF);
      axi_read(4'h0, 0, 32'hABCD_E011);

      // random traffic
      for (int it = 0; it < 80; it++) begin
         int op;
         logic [31:0] d;
         op = int'($urandom_range(0, 9));
         ra = 4'($urandom);
         if (op <= 4) begin
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d[7:0] = codes[$urandom_range(0, 2)];
            wstrb = 4'($urandom);
            axi_write(ra, d, wstrb, int'($urandom_range(0, 2)), 1'b0);
            model_write(ra, d, wstrb);
            check_fields();
         end else if (op <= 7) begin
            axi_read(ra, int'($urandom_range(0, 2)), model_read(ra));
         end else begin
            pulse_done(op == 8);
         end
      end

      // async reset in the middle of a write handshake
      axi_write(4'h8, 32'h0000_0010, 4'h1, 0, 1'b0);
      model_write(4'h8, 32'h0000_0010, 4'h1);
      chk("pre_reset_kernel_size", 32'(kernel_size), 32'h10);
      @(negedge clk);
      awaddr = 4'h0; wdata = 32'h0000_0057; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("mid_hs_awready", 32'(awready), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_awready", 32'({awready, wready}), 32'd0);
      chk("async_rst_kernel_size", 32'(kernel_size), 32'd0);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("async_rst_bvalid", 32'(bvalid), 32'd0);
      chk("async_rst_no_strobe", 32'(cnt_c), 32'(e_c));
      rst = 1'b0;
      model_reset();
      check_fields();
      axi_read(4'h0, 0, 32'd0);
      axi_write(4'h4, 32'h0000_100D, 4'h3, 0, 1'b0);
      model_write(4'h4, 32'h0000_100D, 4'h3);
      axi_read(4'h4, 0, 32'h0000_100D);
      check_fields();

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_lite_ctrl_regs.md
# axi_lite_ctrl_regs

AXI4-Lite responder holding the accelerator's control/status registers. Terminates the host's configuration writes (instruction, channel counts, function/width/stride, kernel size) and status reads. It also issues single-cycle start strobes to the compute, ifmap-load and weight-write engines. It sits inside `top`, between the PS AXI-Lite port and the datapath controllers.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; ADDR[3:2] selects register, ADDR[1:0] ignored

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  asynchronous active-high reset
- AXI4-Lite slave channels:
  - S_AXI_AWADDR/AWPROT/AWVALID  in  4/3/1; S_AXI_AWREADY  out  1
  - S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1
  - S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1
  - S_AXI_ARADDR/ARPROT/ARVALID  in  4/3/1; S_AXI_ARREADY  out  1
  - S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1
- Configuration outputs (decoded register fields):
  - ofmaps_channel  out  12  REG0[31:20]
  - input_channel  out  12  REG0[19:8]
  - func  out  2  REG1[1:0] (0 CONV, 1 POOL)
  - ofmaps_width  out  9  REG1[10:2]
  - stride  out  3  REG1[13:11]
  - kernel_size  out  5  REG2[4:0], one-hot (1..5)
- Start strobes and done inputs:
  - compute_start / load_ifmaps_start / write_weight_start  out  1 each; one-cycle strobes
  - weight_done, compute_done  in  1 each; one-cycle done pulses from engines

## Operation
- Register map:
  - 0x0 REG0 RW: [7:0] instruction, [19:8] input_channel, [31:20] ofmaps_channel
  - 0x4 REG1 RW: bits [31:14] read 0
  - 0x8 REG2 RW: bits [31:5] read 0
  - 0xC REG3 RO status: bit0 weight_finish, bit1 compute_finish, rest 0
- Byte strobes: WSTRB[n] updates byte n only; masked bytes keep their value.
- Writes to REG3 are discarded; they still return OKAY.
- Instruction decode: when a REG0 write has WSTRB[0]=1, WDATA[7:0] selects a strobe:
  - 87 → compute_start
  - 88 → load_ifmaps_start
  - 12 → write_weight_start
  - any other code → no strobe, but the byte is stored.
- A REG0 write with WSTRB[0]=0 (e.g. 4'b1110) updates the channel fields only and never strobes.
- weight_finish:
  - set by weight_done
  - cleared when write_weight_start fires
  - done and clear in the same cycle → set wins
- compute_finish: same rule, using compute_done and compute_start.
- BRESP and RRESP are always 2'b00.

## Timing
- Reset values:
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0
  - all registers, status bits, strobes and RDATA = 0
- Write FSM, states W_IDLE → W_ACK → W_RESP:
  - W_IDLE: wait until AWVALID && WVALID are both high. Either one alone is never accepted.
  - W_ACK, 1 cycle: AWREADY=WREADY=1. Register update and strobe are registered at this handshake edge.
  - W_RESP: BVALID=1 until BREADY; then back to W_IDLE.
  - While BVALID=1, AWREADY/WREADY stay 0. The master holding AWVALID/WVALID until it sees BVALID must not cause a second write.
- Write latency:
  - AWREADY/WREADY rise 1 cycle after both valids are seen.
  - The strobe and BVALID appear in the cycle after the handshake.
  - New field values are visible on the outputs in that same cycle.
- Read FSM, states R_IDLE → R_ACK → R_DATA:
  - R_IDLE: wait for ARVALID.
  - R_ACK, 1 cycle: ARREADY=1; RDATA is captured at this edge.
  - R_DATA: RVALID=1, RDATA held stable until RREADY; then back to R_IDLE.
  - ARREADY stays 0 while RVALID=1.
- Read and write channels are independent and may complete in the same cycle.
- A read of REG0 issued in the same cycle as a REG0 write returns the old value.
- Async reset mid-transaction:
  - drops every VALID/READY and strobe immediately
  - clears all registers
  - the master must restart the transaction.

## Test plan
- REG2 write of 0x00000002 with WSTRB=4'hF → one AWREADY/WREADY pulse, then BVALID held until BREADY; kernel_size=5'b00010; no strobes.
- REG0 write of {12'd2,12'd2,8'd0} with WSTRB=4'b1110 → ofmaps_channel=2, input_channel=2, no strobes; then a REG0 write of 87 with WSTRB=4'b0001 → exactly one compute_start pulse, channel fields unchanged.
- REG1 write of {18'd0,3'd2,9'd3,2'd1} → stride=2, ofmaps_width=3, func=1; readback of 0x4 returns 0x00001 00D.
- Write 12 to REG0 → write_weight_start pulse; read 0xC returns 0. Pulse weight_done, read 0xC returns 1. Write 12 again → status reads 0.
- Master holds AWVALID/WVALID high for 5 cycles after the handshake while BREADY=0 → only one write and one strobe occur.
- Read 0xC with RREADY low for 4 cycles → RVALID and RDATA stay stable; a weight_done arriving in the same cycle as write_weight_start leaves weight_finish=1.
